// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory-stall, branch-squash and interrupt-entry drain.
// Optional stall-cycle counter output enabled by defining STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dec_rsrc1,
  input  logic [2:0]       dec_rsrc2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             ex_mem_rd,
  input  logic [2:0]       ex_rdst,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             int_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             da_en,
  output logic             da_flush,
  output logic             am_en,
  output logic             int_ack
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  if (DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipe_hazard_ctrl: DRAIN_CYCLES and CNT_W must both be >= 1");
  end

  typedef enum logic [1:0] {
    RUN,
    INT_DRAIN,
    INT_ACK
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic          hazard;
  logic          accept;

  assign hazard = ex_mem_rd &&
                  ((dec_use1 && (dec_rsrc1 == ex_rdst)) ||
                   (dec_use2 && (dec_rsrc2 == ex_rdst)));

  assign accept = (state == RUN) && int_req && !branch_taken && !hazard;

  always_comb begin
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    da_en    = 1'b0;
    da_flush = 1'b0;
    am_en    = 1'b0;
    int_ack  = 1'b0;
    if (rst) begin
      fd_flush = 1'b1;
      da_flush = 1'b1;
    end else if (!mem_busy) begin
      // Every non-stalled path advances the decode/ALU and ALU/mem buffers.
      da_en = 1'b1;
      am_en = 1'b1;
      case (state)
        RUN: begin
          if (branch_taken) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            da_flush = 1'b1;
          end else if (hazard) begin
            da_flush = 1'b1;
          end else if (int_req) begin
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            da_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
          end
        end
        INT_DRAIN: begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          da_flush = 1'b1;
        end
        INT_ACK: begin
          int_ack  = 1'b1;
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          da_flush = 1'b1;
        end
        default: begin
          da_en = 1'b0;
          am_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!mem_busy) begin
      case (state)
        RUN: begin
          if (accept) begin
            cnt   <= DW'(DRAIN_CYCLES - 1);
            state <= (DRAIN_CYCLES == 1) ? INT_ACK : INT_DRAIN;
          end
        end
        INT_DRAIN: begin
          // Counter holds the drain cycles still owed including this one.
          cnt <= cnt - DW'(1);
          if (cnt == DW'(1)) state <= INT_ACK;
        end
        INT_ACK: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model of the pipeline control rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DRAIN = 3;
  localparam int unsigned CW    = 16;

  logic       clk = 1'b0;
  logic       rst, mem_busy, branch_taken, int_req, ex_mem_rd, dec_use1, dec_use2;
  logic [2:0] dec_rsrc1, dec_rsrc2, ex_rdst;
  logic       pc_en, fd_en, fd_flush, da_en, da_flush, am_en, int_ack;
`ifdef STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Model: inside an interrupt sequence, m_wait counts drain cycles left before the ack cycle.
  bit      m_in_int = 1'b0;
  int      m_wait   = 0;
  longint  m_sc     = 0;
  bit [6:0] last_exp;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_rsrc1(dec_rsrc1), .dec_rsrc2(dec_rsrc2),
    .dec_use1(dec_use1), .dec_use2(dec_use2),
    .ex_mem_rd(ex_mem_rd), .ex_rdst(ex_rdst),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .da_en(da_en), .da_flush(da_flush), .am_en(am_en), .int_ack(int_ack)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance the model at the clock edge.
  task automatic cycle(input bit r, input bit mb, input bit bt, input bit ir,
                       input bit emr, input bit [2:0] rd, input bit [2:0] s1, input bit [2:0] s2,
                       input bit u1, input bit u2, input string tag);
    bit       haz;
    bit [6:0] e;   // {pc_en, fd_en, fd_flush, da_en, da_flush, am_en, int_ack}
    rst = r; mem_busy = mb; branch_taken = bt; int_req = ir;
    ex_mem_rd = emr; ex_rdst = rd; dec_rsrc1 = s1; dec_rsrc2 = s2;
    dec_use1 = u1; dec_use2 = u2;
    haz = emr && ((u1 && s1 == rd) || (u2 && s2 == rd));
    if (r)                          e = 7'b0010100;
    else if (mb)                    e = 7'b0000000;
    else if (m_in_int && m_wait==0) e = 7'b1111111;
    else if (m_in_int)              e = 7'b0111110;
    else if (bt)                    e = 7'b1111110;
    else if (haz)                   e = 7'b0001110;
    else if (ir)                    e = 7'b0111110;
    else                            e = 7'b1101010;
    last_exp = e;
    #3;
    check(tag, {25'd0, pc_en, fd_en, fd_flush, da_en, da_flush, am_en, int_ack}, {25'd0, e});
`ifdef STALL_CNT_EN
    check({tag, "_cnt"}, {16'd0, stall_cnt}, m_sc[31:0]);
`endif
    @(posedge clk);
    if (r) begin
      m_in_int = 1'b0;
      m_sc     = 0;
    end else begin
      if (!e[6] && m_sc < (longint'(1) << CW) - 1) m_sc++;
      if (!mb) begin
        if (m_in_int) begin
          if (m_wait == 0) m_in_int = 1'b0;
          else m_wait--;
        end else if (!bt && !haz && ir) begin
          m_in_int = 1'b1;
          m_wait   = DRAIN - 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input bit ir, input string tag);
    cycle(0, 0, 0, ir, 0, 3'd0, 3'd0, 3'd0, 0, 0, tag);
  endtask

  initial begin
    bit req = 1'b0;
    @(posedge clk); #1;
    // Reset dominates busy and interrupt request
    cycle(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, "reset");
    idle(0, "post_reset");
    // Load-use bubble on rsrc2, then normal flow
    cycle(0, 0, 0, 0, 1, 3'd3, 3'd5, 3'd3, 0, 1, "load_use");
    idle(0, "after_bubble");
    // Branch overrides the hazard
    cycle(0, 0, 1, 0, 1, 3'd3, 3'd3, 3'd3, 1, 1, "branch_hazard");
    // Two-cycle memory stall
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "mem_busy1");
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, "mem_busy2");
    idle(0, "after_busy");
    // Interrupt: accept, two drains, ack
    for (int i = 0; i < 4; i++) idle(1, $sformatf("int_seq%0d", i));
    idle(0, "after_ack");
    // Interrupt with a busy cycle mid-drain
    idle(1, "int_b_accept");
    cycle(0, 0, 1, 1, 1, 3'd1, 3'd1, 3'd1, 1, 1, "int_b_drain1");
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "int_b_busy");
    idle(1, "int_b_drain2");
    idle(1, "int_b_ack");
    idle(0, "int_b_done");
    // Reset mid-drain aborts the sequence
    idle(1, "int_r_accept");
    idle(1, "int_r_drain");
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "int_r_reset");
    idle(0, "int_r_run");
    idle(0, "int_r_run2");
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!req) req = ($urandom_range(9) == 0);
      cycle($urandom_range(49) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0, req,
            $urandom_range(2) == 0, 3'($urandom_range(3)), 3'($urandom_range(3)),
            3'($urandom_range(3)), 1'($urandom), 1'($urandom), "random");
      if (last_exp[0] && $urandom_range(7) != 0) req = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the PC enable and the enable/flush controls of the fetch/decode, decode/ALU and ALU/mem pipeline buffers.
- Resolves load-use hazards, multi-cycle memory stalls and taken-branch squashes.
- Runs an interrupt-entry FSM that drains in-flight instructions before handing the PC to the interrupt vector.

Parameters:
- DRAIN_CYCLES, 3, cycles spent draining older instructions after interrupt acceptance (>=1)
- CNT_W, 16, width of optional stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- dec_rsrc1  in  3  source register 1 of instruction in decode
- dec_rsrc2  in  3  source register 2 of instruction in decode
- dec_use1  in  1  decode instruction reads rsrc1
- dec_use2  in  1  decode instruction reads rsrc2
- ex_mem_rd  in  1  instruction in ALU stage is a load
- ex_rdst  in  3  destination register of instruction in ALU stage
- branch_taken  in  1  ALU stage resolved a taken branch/jump this cycle
- mem_busy  in  1  memory stage needs at least one more cycle (level)
- int_req  in  1  interrupt request (level, held until int_ack)
- pc_en  out  1  PC register load enable
- fd_en  out  1  fetch/decode buffer enable
- fd_flush  out  1  fetch/decode buffer loads bubble
- da_en  out  1  decode/ALU buffer enable
- da_flush  out  1  decode/ALU buffer loads bubble (all control fields zero)
- am_en  out  1  ALU/mem buffer enable
- int_ack  out  1  one-cycle pulse: PC loads interrupt vector this cycle
- stall_cnt  out  CNT_W  stall-cycle count (only with STALL_CNT_EN)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Outputs are combinational from registered state plus current inputs. State and drain counter are registered.
- States: RUN, INT_DRAIN, INT_ACK.
- Reset cycle (rst=1) forces outputs regardless of inputs: pc_en=0, fd_en=0, da_en=0, am_en=0, fd_flush=1, da_flush=1, int_ack=0. Next state RUN, counter 0, stall_cnt 0.
- Priority in every state: rst > mem_busy > state-specific rules.
- mem_busy=1 in any state: all enables 0, flushes 0, int_ack 0. State and counter hold (drain pauses). Resumes the cycle mem_busy drops.
- Load-use hazard is true when ex_mem_rd=1 and ((dec_use1 and dec_rsrc1==ex_rdst) or (dec_use2 and dec_rsrc2==ex_rdst)).
- RUN, branch_taken=1: pc_en=1, fd_en=1, fd_flush=1, da_en=1, da_flush=1, am_en=1. Two younger instructions are squashed; any load-use hazard is ignored.
- RUN, hazard=1 (no branch): pc_en=0, fd_en=0, da_en=1, da_flush=1, am_en=1. Exactly one bubble; the hazard clears naturally the next cycle.
- RUN, otherwise: all enables 1, flushes 0.
- Interrupt acceptance: RUN with int_req=1, branch_taken=0, hazard=0, mem_busy=0.
  - In the accept cycle: pc_en=0, fd_en=1, fd_flush=1, da_en=1, da_flush=1, am_en=1.
  - Counter loads DRAIN_CYCLES-1; next state is INT_DRAIN, or INT_ACK if DRAIN_CYCLES=1.
- INT_DRAIN: pc_en=0, fd_en=1, fd_flush=1, da_en=1, da_flush=1, am_en=1. Counter decrements; at 0 the next state is INT_ACK. branch_taken and hazard are ignored.
- INT_ACK: int_ack=1, pc_en=1, fd_en=1, fd_flush=1, da_en=1, da_flush=1, am_en=1. Next state RUN.
- int_req is ignored outside RUN. If it is still high after INT_ACK, it is re-accepted (requester must drop on int_ack).
- rst mid-drain aborts to RUN with no int_ack.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: stall_cnt port exists. It increments by 1 on every non-reset cycle with pc_en=0, saturates at all-ones and clears on rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- rst=1 one cycle with int_req=1, mem_busy=1 -> pc_en=0, all buffer enables 0, fd_flush=da_flush=1, int_ack=0; next cycle RUN, all enables 1.
- ex_mem_rd=1, ex_rdst=3, dec_use2=1, dec_rsrc2=3 for one cycle -> pc_en=0, fd_en=0, da_flush=1, am_en=1 that cycle; next cycle all enables 1.
- branch_taken=1 together with load-use hazard -> pc_en=1, fd_flush=1, da_flush=1, no stall.
- mem_busy high 2 cycles while in RUN -> all enables 0 for exactly 2 cycles, then normal; with STALL_CNT_EN, stall_cnt advances by 2.
- int_req=1 in RUN, DRAIN_CYCLES=3 -> accept cycle + 2 INT_DRAIN cycles with pc_en=0, then int_ack=1 with pc_en=1 on cycle 4. Then assert mem_busy mid-drain for 1 cycle -> int_ack delayed by 1.
- rst asserted in INT_DRAIN -> no int_ack; RUN after reset.
